// File: rtl/graphic_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : graphic_cmd_scheduler
// Brief    : Per-scanline command scheduler. Clears the line buffer to a
//            background colour, walks the command table and dispatches every
//            in-range command to the string/line/rect/fill engine, owning the
//            single line-buffer write port while an engine runs.
// Revision : 1.0 - initial release
// ============================================================================
module graphic_cmd_scheduler #(
    parameter int CMD_AW  = 4,
    parameter int H_RES   = 800,
    parameter int TIMEOUT = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              line_start,
    input  logic [10:0]       line,
    input  logic              clear_en,
    input  logic [3:0]        bg_color,
    input  logic [CMD_AW:0]   cmd_count,
    output logic [CMD_AW-1:0] cmd_addr,
    input  logic [63:0]       cmd_data,
    output logic [63:0]       eng_cmd,
    output logic [3:0]        eng_start,
    input  logic [3:0]        eng_done,
    input  logic [15:0]       eng_buff_data,
    input  logic [47:0]       eng_buff_addr,
    input  logic [3:0]        eng_buff_wr,
    output logic [3:0]        buff_data,
    output logic [11:0]       buff_addr,
    output logic              buff_wr,
    output logic              busy,
    output logic              line_done,
    output logic              err
);

    // Timeout counter only has to reach TIMEOUT-1: RUN lasts at most
    // TIMEOUT ce-cycles, counting the first one as cycle 0.
    localparam int              c_tw       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);
    localparam logic [11:0]     c_clr_last = 12'(H_RES - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_clear   = 3'd1;
    localparam logic [2:0] c_st_fetch   = 3'd2;
    localparam logic [2:0] c_st_wait_rd = 3'd3;
    localparam logic [2:0] c_st_decode  = 3'd4;
    localparam logic [2:0] c_st_run     = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    logic [2:0]        r_state;
    logic [10:0]       r_line;
    logic [CMD_AW:0]   r_index;
    logic [11:0]       r_clr_addr;
    logic [1:0]        r_sel;
    logic [c_tw-1:0]   r_tmo;
    logic [CMD_AW-1:0] r_cmd_addr;
    logic [63:0]       r_eng_cmd;
    logic [3:0]        r_eng_start;
    logic              r_busy;
    logic              r_line_done;
    logic              r_err;

    // Per-engine views of the packed engine write buses.
    logic [3:0]  w_eng_data [4];
    logic [11:0] w_eng_addr [4];

    for (genvar k = 0; k < 4; k++) begin : g_eng
        assign w_eng_data[k] = eng_buff_data[4*k +: 4];
        assign w_eng_addr[k] = eng_buff_addr[12*k +: 12];
    end

    // Command decode: opcodes 1..4 map to engines 0..3.
    logic [2:0]  w_op;
    logic [2:0]  w_op_m1;
    logic [1:0]  w_eng;
    logic [10:0] w_y0;
    logic [10:0] w_y1;
    logic        w_valid_op;
    logic        w_in_range;

    assign w_op       = cmd_data[2:0];
    assign w_op_m1    = w_op - 3'd1;
    assign w_eng      = w_op_m1[1:0];
    assign w_y0       = cmd_data[44:34];
    assign w_y1       = cmd_data[22:12];
    assign w_valid_op = (w_op >= 3'd1) && (w_op <= 3'd4);
    // An inverted range (y0 > y1) can never satisfy both compares.
    assign w_in_range = (w_y0 <= r_line) && (r_line <= w_y1);

    assign cmd_addr  = r_cmd_addr;
    assign eng_cmd   = r_eng_cmd;
    assign eng_start = r_eng_start;
    assign busy      = r_busy;
    assign line_done = r_line_done;
    assign err       = r_err;

    // Scheduler FSM: clear, then fetch/decode/run each table entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_line      <= '0;
            r_index     <= '0;
            r_clr_addr  <= '0;
            r_sel       <= '0;
            r_tmo       <= '0;
            r_cmd_addr  <= '0;
            r_eng_cmd   <= '0;
            r_eng_start <= '0;
            r_busy      <= 1'b0;
            r_line_done <= 1'b0;
            r_err       <= 1'b0;
        end else if (ce) begin
            r_eng_start <= '0;
            r_line_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (line_start) begin
                        r_line     <= line;
                        r_index    <= '0;
                        r_clr_addr <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= clear_en ? c_st_clear : c_st_fetch;
                    end
                end
                c_st_clear: begin
                    if (r_clr_addr == c_clr_last) begin
                        r_state <= c_st_fetch;
                    end else begin
                        r_clr_addr <= r_clr_addr + 12'd1;
                    end
                end
                c_st_fetch: begin
                    if (r_index == cmd_count) begin
                        r_line_done <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_cmd_addr <= r_index[CMD_AW-1:0];
                        r_state    <= c_st_wait_rd;
                    end
                end
                c_st_wait_rd: begin
                    r_state <= c_st_decode;
                end
                c_st_decode: begin
                    if (w_op == 3'd0) begin
                        r_line_done <= 1'b1;
                        r_state     <= c_st_done;
                    end else if (w_valid_op && w_in_range) begin
                        r_eng_cmd   <= cmd_data;
                        r_eng_start <= 4'b0001 << w_eng;
                        r_sel       <= w_eng;
                        r_tmo       <= '0;
                        r_state     <= c_st_run;
                    end else begin
                        r_index <= r_index + 1'b1;
                        r_state <= c_st_fetch;
                    end
                end
                c_st_run: begin
                    // A done on the final allowed cycle still counts as done.
                    if (eng_done[r_sel]) begin
                        r_index <= r_index + 1'b1;
                        r_state <= c_st_fetch;
                    end else if (r_tmo == c_tmo_last) begin
                        r_err   <= 1'b1;
                        r_index <= r_index + 1'b1;
                        r_state <= c_st_fetch;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_st_done: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Write port mux: scheduler owns it in CLEAR, the selected engine in RUN.
    always_comb begin
        buff_wr   = 1'b0;
        buff_addr = '0;
        buff_data = '0;
        case (r_state)
            c_st_clear: begin
                buff_wr   = 1'b1;
                buff_addr = r_clr_addr;
                buff_data = bg_color;
            end
            c_st_run: begin
                buff_wr   = eng_buff_wr[r_sel];
                buff_addr = w_eng_addr[r_sel];
                buff_data = w_eng_data[r_sel];
            end
            default: begin
                buff_wr = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_graphic_cmd_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_graphic_cmd_scheduler
// Brief    : Self-checking bench for graphic_cmd_scheduler. A behavioural
//            model expands each scanline into an expected per-ce-cycle trace
//            (outputs plus the engine activity to drive) which the DUT must
//            follow, with random clock-enable gaps and stray inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_graphic_cmd_scheduler;

    localparam int c_aw   = 4;
    localparam int c_hres = 800;
    localparam int c_tmo  = 15;

    logic            clk;
    logic            reset;
    logic            ce;
    logic            line_start;
    logic [10:0]     line;
    logic            clear_en;
    logic [3:0]      bg_color;
    logic [c_aw:0]   cmd_count;
    logic [c_aw-1:0] cmd_addr;
    logic [63:0]     cmd_data;
    logic [63:0]     eng_cmd;
    logic [3:0]      eng_start;
    logic [3:0]      eng_done;
    logic [15:0]     eng_buff_data;
    logic [47:0]     eng_buff_addr;
    logic [3:0]      eng_buff_wr;
    logic [3:0]      buff_data;
    logic [11:0]     buff_addr;
    logic            buff_wr;
    logic            busy;
    logic            line_done;
    logic            err;

    // Command table, per-dispatch engine latencies and scanline setup.
    logic [63:0] r_tbl [16];
    int          lat [16];
    int          cfg_cnt;
    logic [10:0] cfg_line;
    bit          cfg_clr;
    logic [3:0]  cfg_bg;

    // Model view of the sticky state carried across scanlines.
    logic        m_err;
    logic [63:0] m_cmd;

    int n_checks = 0;
    int n_errors = 0;

    // One ce-cycle of the expected trace: engine stimulus and DUT outputs.
    typedef struct packed {
        logic [3:0]  d_done;
        logic [3:0]  d_wr;
        logic [15:0] d_data;
        logic [47:0] d_addr;
        logic        busy;
        logic        ld;
        logic        er;
        logic [3:0]  start;
        logic        wr;
        logic        care;
        logic [11:0] addr;
        logic [3:0]  data;
        logic [63:0] cmd;
    } cyc_t;

    cyc_t q[$];

    graphic_cmd_scheduler #(
        .CMD_AW (c_aw),
        .H_RES  (c_hres),
        .TIMEOUT(c_tmo)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ce           (ce),
        .line_start   (line_start),
        .line         (line),
        .clear_en     (clear_en),
        .bg_color     (bg_color),
        .cmd_count    (cmd_count),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .eng_cmd      (eng_cmd),
        .eng_start    (eng_start),
        .eng_done     (eng_done),
        .eng_buff_data(eng_buff_data),
        .eng_buff_addr(eng_buff_addr),
        .eng_buff_wr  (eng_buff_wr),
        .buff_data    (buff_data),
        .buff_addr    (buff_addr),
        .buff_wr      (buff_wr),
        .busy         (busy),
        .line_done    (line_done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous command table: data valid one ce-cycle after the address.
    always @(posedge clk) begin
        if (ce) cmd_data <= r_tbl[cmd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [2:0] op, input logic [10:0] y0, input logic [10:0] y1);
        logic [63:0] w;
        w        = {$urandom, $urandom};
        w[2:0]   = op;
        w[44:34] = y0;
        w[22:12] = y1;
        return w;
    endfunction

    function automatic logic [10:0] near();
        int v;
        v = int'(cfg_line) + int'($urandom_range(12)) - 6;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        return 11'(v);
    endfunction

    // A busy, non-writing cycle with random engine noise on every input.
    function automatic cyc_t base_cyc();
        cyc_t c;
        c        = '0;
        c.d_done = 4'($urandom);
        c.d_wr   = 4'($urandom);
        c.d_data = 16'($urandom);
        c.d_addr = 48'({$urandom, $urandom});
        c.busy   = 1'b1;
        c.er     = m_err;
        c.cmd    = m_cmd;
        return c;
    endfunction

    // Expand the current scanline setup into the expected ce-cycle trace.
    task automatic build_model();
        cyc_t        c;
        logic [63:0] w;
        int          idx;
        int          d;
        int          k;
        int          l;
        int          run;
        bit          to;
        idx = 0;
        d   = 0;
        q.delete();
        if (cfg_clr) begin
            for (int a = 0; a < c_hres; a++) begin
                c      = base_cyc();
                c.wr   = 1'b1;
                c.care = 1'b1;
                c.addr = 12'(a);
                c.data = cfg_bg;
                q.push_back(c);
            end
        end
        forever begin
            if (idx == cfg_cnt) begin
                q.push_back(base_cyc());
                c    = base_cyc();
                c.ld = 1'b1;
                q.push_back(c);
                break;
            end
            w = r_tbl[idx];
            repeat (3) q.push_back(base_cyc());
            if (w[2:0] == 3'd0) begin
                c    = base_cyc();
                c.ld = 1'b1;
                q.push_back(c);
                break;
            end
            if (w[2:0] <= 3'd4 && w[44:34] <= cfg_line && cfg_line <= w[22:12]) begin
                k     = int'(w[2:0]) - 1;
                l     = lat[d % 16];
                d++;
                to    = (l > c_tmo);
                run   = to ? c_tmo : l;
                m_cmd = w;
                for (int j = 0; j < run; j++) begin
                    c           = base_cyc();
                    c.start     = (j == 0) ? 4'(1 << k) : 4'b0000;
                    c.d_done[k] = (!to && j == l - 1);
                    c.wr        = c.d_wr[k];
                    c.care      = 1'b1;
                    c.addr      = c.d_addr[12*k +: 12];
                    c.data      = c.d_data[4*k +: 4];
                    q.push_back(c);
                end
                if (to) m_err = 1'b1;
            end
            idx++;
        end
    endtask

    task automatic drive(input cyc_t c);
        eng_done      = c.d_done;
        eng_buff_wr   = c.d_wr;
        eng_buff_data = c.d_data;
        eng_buff_addr = c.d_addr;
    endtask

    task automatic check_idle(input string tag, input bit port);
        check({tag, "_ctl"}, 64'({busy, line_done, err, eng_start, buff_wr}),
              64'({1'b0, 1'b0, m_err, 4'b0000, 1'b0}));
        check({tag, "_cmd"}, eng_cmd, m_cmd);
        if (port) check({tag, "_port"}, 64'({buff_addr, buff_data}), 64'(0));
    endtask

    task automatic cmp(input cyc_t c);
        check("ctl", 64'({busy, line_done, err, eng_start, buff_wr}),
              64'({c.busy, c.ld, c.er, c.start, c.wr}));
        if (c.care) check("port", 64'({buff_addr, buff_data}), 64'({c.addr, c.data}));
        check("cmd", eng_cmd, c.cmd);
    endtask

    // Render one scanline; optional ce stall and mid-line reset.
    task automatic run_line(input bit ce_rand, input int stall_at, input int abort_at);
        int n;
        int stall;
        n     = 0;
        stall = 0;
        @(posedge clk); #1;
        reset      = 1'b0;
        ce         = 1'b1;
        line_start = 1'b1;
        line       = cfg_line;
        clear_en   = cfg_clr;
        bg_color   = cfg_bg;
        cmd_count  = cfg_cnt[c_aw:0];
        drive(base_cyc());
        @(negedge clk);
        check_idle("accept", 1'b0);
        build_model();
        while (n < q.size()) begin
            @(posedge clk); #1;
            if (n == abort_at) begin
                ce    = 1'b1;
                reset = 1'b1;
            end else if (n == stall_at && stall < 10) begin
                ce = 1'b0;
                stall++;
            end else begin
                ce = ce_rand ? ($urandom_range(3) != 0) : 1'b1;
            end
            line_start = 1'($urandom_range(1));
            line       = 11'($urandom);
            clear_en   = 1'($urandom_range(1));
            drive(q[n]);
            @(negedge clk);
            cmp(q[n]);
            if (n == abort_at) begin
                @(posedge clk); #1;
                reset      = 1'b0;
                ce         = 1'b1;
                line_start = 1'b0;
                drive(base_cyc());
                m_err = 1'b0;
                m_cmd = '0;
                @(negedge clk);
                check_idle("post_reset", 1'b1);
                return;
            end
            if (ce) n++;
        end
        @(posedge clk); #1;
        ce         = 1'b1;
        line_start = 1'b0;
        drive(base_cyc());
        @(negedge clk);
        check_idle("end", 1'b1);
    endtask

    task automatic rand_cfg();
        logic [2:0] op;
        cfg_line = 11'($urandom);
        cfg_clr  = ($urandom_range(7) == 0);
        cfg_bg   = 4'($urandom);
        cfg_cnt  = $urandom_range(16);
        for (int i = 0; i < 16; i++) begin
            op       = ($urandom_range(9) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
            r_tbl[i] = mk(op, near(), near());
            case ($urandom_range(9))
                0:       lat[i] = 40;
                1:       lat[i] = c_tmo;
                default: lat[i] = $urandom_range(6, 1);
            endcase
        end
    endtask

    initial begin
        reset         = 1'b1;
        ce            = 1'b1;
        line_start    = 1'b0;
        line          = '0;
        clear_en      = 1'b0;
        bg_color      = '0;
        cmd_count     = '0;
        eng_done      = '0;
        eng_buff_data = '0;
        eng_buff_addr = '0;
        eng_buff_wr   = '0;
        m_err         = 1'b0;
        m_cmd         = '0;
        for (int i = 0; i < 16; i++) begin
            r_tbl[i] = '0;
            lat[i]   = 1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset", 1'b1);
        check("reset_cmd_addr", 64'(cmd_addr), 64'(0));

        // Empty list, no clear: FETCH then DONE.
        cfg_line = 11'd5; cfg_clr = 1'b0; cfg_bg = 4'h3; cfg_cnt = 0;
        run_line(1'b0, -1, -1);

        // Background clear of a full line.
        cfg_line = 11'd9; cfg_clr = 1'b1; cfg_bg = 4'hA; cfg_cnt = 0;
        run_line(1'b0, -1, -1);

        // Range dispatch: string hit, rect miss, line hit on y0==y1, END stops.
        cfg_line = 11'd100; cfg_clr = 1'b0; cfg_bg = 4'h0; cfg_cnt = 5;
        r_tbl[0] = mk(3'd1, 11'd90, 11'd110);
        r_tbl[1] = mk(3'd3, 11'd0, 11'd50);
        r_tbl[2] = mk(3'd2, 11'd100, 11'd100);
        r_tbl[3] = mk(3'd0, 11'd0, 11'd0);
        r_tbl[4] = mk(3'd1, 11'd0, 11'd2047);
        lat[0] = 3; lat[1] = 2;
        run_line(1'b0, -1, -1);

        // Engine timeout, next command still dispatched; ce frozen 10 cycles mid-RUN.
        cfg_line = 11'd7; cfg_clr = 1'b0; cfg_cnt = 2;
        r_tbl[0] = mk(3'd2, 11'd0, 11'd2047);
        r_tbl[1] = mk(3'd4, 11'd7, 11'd7);
        lat[0] = 40; lat[1] = 1;
        run_line(1'b0, 5, -1);

        // Full table of reserved opcodes ending in one hit; terminates at 16.
        cfg_line = 11'd1000; cfg_clr = 1'b0; cfg_cnt = 16;
        for (int i = 0; i < 15; i++) r_tbl[i] = mk(3'($urandom_range(7, 5)), 11'd0, 11'd2047);
        r_tbl[15] = mk(3'd3, 11'd1000, 11'd1000);
        lat[0] = 2;
        run_line(1'b1, -1, -1);

        // Reset while an engine is running.
        cfg_line = 11'd0; cfg_clr = 1'b0; cfg_cnt = 1;
        r_tbl[0] = mk(3'd3, 11'd0, 11'd0);
        lat[0] = 40;
        run_line(1'b0, -1, 6);

        // Randomised scanlines with random clock-enable gaps.
        for (int t = 0; t < 16; t++) begin
            rand_cfg();
            run_line(1'b1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
